accelerator_write_key_transmitter: RTL and testbench

- Producer end of the write-key element stream (K_OUT / K_OUT_ENABLE, one element per enable pulse, W elements per vector).
- Buffers a write-key vector k^(t) of W elements as the controller supplies it, then emits it element by element to the write-key stage of the DNC write heads.
- Supports downstream throttling through a stall input.
- Sits between the controller output interface and the write-head key path.

---
 rtl/accelerator_dnc_pkg.sv | 10 +
 rtl/accelerator_write_key_transmitter_if.sv | 25 ++
 rtl/accelerator_key_buffer.sv | 22 ++
 rtl/accelerator_write_key_transmitter.sv | 97 +++++++++
 tb/tb_accelerator_write_key_transmitter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/accelerator_dnc_pkg.sv
// accelerator_dnc_pkg: shared FSM states, constants and default widths for the DNC accelerator key path.
package accelerator_dnc_pkg;
    localparam int DATA_SIZE_DEF = 64;
    localparam int CONTROL_SIZE_DEF = 64;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
    localparam logic [CONTROL_SIZE_DEF-1:0] CONTROL_ZERO = '0;
    localparam logic [CONTROL_SIZE_DEF-1:0] CONTROL_ONE = 1;
    localparam logic [DATA_SIZE_DEF-1:0] DATA_ZERO = '0;
    localparam logic [DATA_SIZE_DEF-1:0] DATA_ONE = 1;
endpackage

// File: rtl/accelerator_write_key_transmitter_if.sv
// accelerator_write_key_transmitter_if: controller load side and write-head key stream side of the transmitter.
// REPLAY is present only with ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN.
interface accelerator_write_key_transmitter_if
    import accelerator_dnc_pkg::*;
#(parameter int DATA_SIZE = DATA_SIZE_DEF);
    logic START, READY, ERROR, K_IN_ENABLE, K_OUT_STALL, K_OUT_ENABLE;
    logic [DATA_SIZE-1:0] K_IN, SIZE_W_IN, K_OUT;
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
    logic REPLAY;
`endif
    modport master(
        output START, K_IN_ENABLE, K_IN, SIZE_W_IN, K_OUT_STALL,
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
        output REPLAY,
`endif
        input READY, ERROR, K_OUT_ENABLE, K_OUT
    );
    modport slave(
        input START, K_IN_ENABLE, K_IN, SIZE_W_IN, K_OUT_STALL,
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
        input REPLAY,
`endif
        output READY, ERROR, K_OUT_ENABLE, K_OUT
    );
endinterface

// File: rtl/accelerator_key_buffer.sv
// accelerator_key_buffer: key register file, one synchronous write port and an enabled, resettable registered read port.
module accelerator_key_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);
    logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
    always_ff @(posedge CLK)
        if (wr_en) mem[wr_addr] <= wr_data;
    // The read register is the visible K_OUT: it resets to zero and holds while not enabled.
    always_ff @(posedge CLK or posedge RST)
        if (RST) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/accelerator_write_key_transmitter.sv
// accelerator_write_key_transmitter: buffers a W-element write key, then streams it one element per unstalled cycle.
// Optional ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN re-streams the last accepted vector without reloading.
module accelerator_write_key_transmitter
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CONTROL_SIZE = CONTROL_SIZE_DEF,
    parameter int ADDR_SIZE = 4
) (
    input logic CLK,
    input logic RST,
    accelerator_write_key_transmitter_if.slave bus
);
    localparam logic [CONTROL_SIZE-1:0] C0 = CONTROL_SIZE'(CONTROL_ZERO);
    localparam logic [CONTROL_SIZE-1:0] C1 = CONTROL_SIZE'(CONTROL_ONE);
    localparam logic [CONTROL_SIZE-1:0] DEPTH = C1 << ADDR_SIZE;
    state_t state, state_nxt;
    logic [CONTROL_SIZE-1:0] load_idx, load_idx_nxt, send_idx, send_idx_nxt, size_w_int, size_w_nxt, size_w_in;
    logic ready_nxt, error_nxt, enable_nxt, replay;
    assign size_w_in = CONTROL_SIZE'(bus.SIZE_W_IN);
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
    assign replay = bus.REPLAY;
`else
    assign replay = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        load_idx_nxt = load_idx;
        send_idx_nxt = send_idx;
        size_w_nxt = size_w_int;
        ready_nxt = 1'b0;
        error_nxt = 1'b0;
        enable_nxt = 1'b0;
        case (state)
            IDLE:
                if (bus.START) begin
                    if (size_w_in == C0 || size_w_in > DEPTH) error_nxt = 1'b1;
                    else begin
                        size_w_nxt = size_w_in;
                        load_idx_nxt = C0;
                        state_nxt = LOAD;
                    end
                end else if (replay) begin
                    // size_w_int stays zero until a START is accepted, so it marks "nothing to replay".
                    if (size_w_int == C0) error_nxt = 1'b1;
                    else begin
                        send_idx_nxt = C0;
                        state_nxt = STREAM;
                    end
                end
            LOAD:
                if (bus.K_IN_ENABLE) begin
                    if (load_idx == size_w_int - C1) begin
                        send_idx_nxt = C0;
                        state_nxt = STREAM;
                    end else load_idx_nxt = load_idx + C1;
                end
            STREAM:
                if (!bus.K_OUT_STALL) begin
                    enable_nxt = 1'b1;
                    if (send_idx == size_w_int - C1) begin
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else send_idx_nxt = send_idx + C1;
                end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state <= IDLE;
            load_idx <= C0;
            send_idx <= C0;
            size_w_int <= C0;
            bus.READY <= 1'b0;
            bus.ERROR <= 1'b0;
            bus.K_OUT_ENABLE <= 1'b0;
        end else begin
            state <= state_nxt;
            load_idx <= load_idx_nxt;
            send_idx <= send_idx_nxt;
            size_w_int <= size_w_nxt;
            bus.READY <= ready_nxt;
            bus.ERROR <= error_nxt;
            bus.K_OUT_ENABLE <= enable_nxt;
        end
    accelerator_key_buffer #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_buf (
        .CLK(CLK),
        .RST(RST),
        .wr_en(state == LOAD && bus.K_IN_ENABLE),
        .wr_addr(load_idx[ADDR_SIZE-1:0]),
        .wr_data(bus.K_IN),
        .rd_en(state == STREAM && !bus.K_OUT_STALL),
        .rd_addr(send_idx[ADDR_SIZE-1:0]),
        .rd_data(bus.K_OUT)
    );
endmodule

// File: tb/tb_accelerator_write_key_transmitter.sv
// tb_accelerator_write_key_transmitter: table-driven and random vector transfers checked against an in-order element model.
module tb_accelerator_write_key_transmitter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;
    accelerator_write_key_transmitter_if #(.DATA_SIZE(64)) bus();
    accelerator_write_key_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(64), .ADDR_SIZE(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );
    typedef struct {
        int unsigned w;
        logic [63:0] first;
        logic [63:0] inc;
        bit          gaps;
        int          stall_pos;
        int          stall_len;
        bit          exp_err;
    } vec_t;
    vec_t tbl [7];
    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] vd [32];
    logic [63:0] model_out = '0;
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic chk_quiet(input string name);
        chk(name, 64'({bus.K_OUT_ENABLE, bus.READY, bus.ERROR}), 64'd0);
    endtask
    // One transfer: START (or REPLAY), loads of vd[0..w-1], then streaming with the chosen stall pattern.
    task automatic xfer(input int unsigned w, input bit gaps, input int stall_pos, input int stall_len,
                        input bit rnd_stall, input bit rep, input bit exp_err);
        int emitted = 0;
        int stalled = 0;
        int cyc = 0;
        bit s;
        if (rep) begin
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
            bus.REPLAY = 1'b1;
`endif
        end else begin
            bus.START = 1'b1;
            bus.SIZE_W_IN = 64'(w);
        end
        step();
        bus.START = 1'b0;
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
        bus.REPLAY = 1'b0;
`endif
        chk("error_on_start", 64'(bus.ERROR), 64'(exp_err));
        chk("no_emit_on_start", 64'(bus.K_OUT_ENABLE), 64'd0);
        if (exp_err) begin
            repeat (3) begin
                step();
                chk_quiet("idle_after_reject");
            end
            return;
        end
        if (!rep) begin
            for (int i = 0; i < int'(w); i++) begin
                if (gaps) repeat ($urandom_range(0, 2)) begin
                    bus.K_IN_ENABLE = 1'b0;
                    bus.START = 1'($urandom_range(0, 1));
                    bus.SIZE_W_IN = {$urandom, $urandom};
                    step();
                    chk_quiet("quiet_in_load_gap");
                end
                bus.K_IN_ENABLE = 1'b1;
                bus.K_IN = vd[i];
                step();
                chk_quiet("quiet_in_load");
            end
            bus.K_IN_ENABLE = 1'b0;
            bus.START = 1'b0;
        end
        while (emitted < int'(w) && cyc < 4 * int'(w) + 40) begin
            s = rnd_stall ? ($urandom_range(0, 3) == 0) : (emitted == stall_pos && stalled < stall_len);
            bus.K_OUT_STALL = s;
            bus.START = 1'($urandom_range(0, 1));
            bus.K_IN_ENABLE = 1'($urandom_range(0, 1));
            bus.K_IN = {$urandom, $urandom};
            step();
            cyc++;
            if (s) begin
                stalled++;
                chk("stall_no_enable", 64'(bus.K_OUT_ENABLE), 64'd0);
                chk("stall_holds_k_out", bus.K_OUT, model_out);
                chk("stall_no_ready", 64'(bus.READY), 64'd0);
            end else begin
                model_out = vd[emitted];
                chk("k_out_enable", 64'(bus.K_OUT_ENABLE), 64'd1);
                chk("k_out", bus.K_OUT, model_out);
                chk("ready_on_last", 64'(bus.READY), 64'(emitted == int'(w) - 1));
                emitted++;
            end
        end
        chk("stream_complete", 64'(emitted), 64'(w));
        bus.K_OUT_STALL = 1'b0;
        bus.START = 1'b0;
        bus.K_IN_ENABLE = 1'b0;
    endtask
    task automatic chk_reset(input string name);
        chk({name, "_ready"}, 64'(bus.READY), 64'd0);
        chk({name, "_error"}, 64'(bus.ERROR), 64'd0);
        chk({name, "_enable"}, 64'(bus.K_OUT_ENABLE), 64'd0);
        chk({name, "_k_out"}, bus.K_OUT, 64'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.START = 1'b0;
        bus.K_IN_ENABLE = 1'b0;
        bus.K_IN = '0;
        bus.SIZE_W_IN = '0;
        bus.K_OUT_STALL = 1'b0;
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
        bus.REPLAY = 1'b0;
`endif
        tbl[0] = '{4, 64'h11, 64'h11, 1'b0, -1, 0, 1'b0};
        tbl[1] = '{3, 64'hA, 64'h1, 1'b1, 1, 2, 1'b0};
        tbl[2] = '{0, 64'h0, 64'h0, 1'b0, -1, 0, 1'b1};
        tbl[3] = '{17, 64'h100, 64'h1, 1'b0, -1, 0, 1'b1};
        tbl[4] = '{1, 64'h5A, 64'h0, 1'b0, -1, 0, 1'b0};
        tbl[5] = '{1, 64'h77, 64'h0, 1'b0, 0, 1, 1'b0};
        tbl[6] = '{16, 64'h1000, 64'h3, 1'b1, 15, 1, 1'b0};
        repeat (2) step();
        chk_reset("reset");
        RST = 1'b0;
        step();
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
        bus.REPLAY = 1'b1;
        step();
        bus.REPLAY = 1'b0;
        chk("replay_without_vector_error", 64'(bus.ERROR), 64'd1);
        chk("replay_without_vector_no_emit", 64'(bus.K_OUT_ENABLE), 64'd0);
        step();
        chk_quiet("replay_error_one_cycle");
`endif
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 32; i++) vd[i] = tbl[t].first + 64'(i) * tbl[t].inc;
            xfer(tbl[t].w, tbl[t].gaps, tbl[t].stall_pos, tbl[t].stall_len, 1'b0, 1'b0, tbl[t].exp_err);
`ifdef ACCELERATOR_WRITE_KEY_TRANSMITTER_REPLAY_EN
            if (t == 0) xfer(4, 1'b0, 2, 1, 1'b0, 1'b1, 1'b0);
`endif
        end
        for (int i = 0; i < 4; i++) vd[i] = 64'hC0DE_0000 + 64'(i);
        bus.START = 1'b1;
        bus.SIZE_W_IN = 64'd4;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.K_IN_ENABLE = 1'b1;
            bus.K_IN = vd[i];
            step();
        end
        bus.K_IN_ENABLE = 1'b0;
        repeat (2) step();
        chk("pre_reset_k_out", bus.K_OUT, vd[1]);
        RST = 1'b1;
        #1;
        chk_reset("async_reset");
        repeat (2) step();
        chk_reset("held_reset");
        RST = 1'b0;
        model_out = '0;
        vd[0] = 64'hBEEF_0001;
        vd[1] = 64'hBEEF_0002;
        xfer(2, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 40; r++) begin
            int unsigned w;
            w = $urandom_range(0, 18);
            for (int i = 0; i < 32; i++) vd[i] = {$urandom, $urandom};
            xfer(w, 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, (w == 0 || w > 16));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
